// File: rtl/booth_mul_arbiter.sv
// +----------------------------------------------------------------------------+
// | booth_mul_arbiter: round-robin sharing of one sequential Booth multiplier.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module booth_mul_arbiter #(
   parameter int N_REQ   = 4,
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   req_x,
   input  logic [N_REQ*WIDTH-1:0]   req_y,
   output logic [N_REQ-1:0]         gnt,
   output logic [N_REQ-1:0]         rsp_valid,
   output logic [2*WIDTH-1:0]       rsp_z,
   output logic                     timeout_err,
   output logic                     busy,
   output logic                     mul_start,
   output logic [WIDTH-1:0]         mul_x,
   output logic [WIDTH-1:0]         mul_y,
   input  logic                     mul_valid,
   input  logic [2*WIDTH-1:0]       mul_z
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t               state_q,  state_d;
   logic [PTR_W-1:0]     ptr_q,    ptr_d;
   logic [PTR_W-1:0]     owner_q,  owner_d;
   logic [WIDTH-1:0]     opx_q,    opx_d;
   logic [WIDTH-1:0]     opy_q,    opy_d;
   logic [2*WIDTH-1:0]   rsp_z_q,  rsp_z_d;
   logic                 err_q,    err_d;
   logic [CNT_W-1:0]     cnt_q,    cnt_d;
   logic                 mul_valid_dly_q;

   logic [WIDTH-1:0]     x_arr [N_REQ];
   logic [WIDTH-1:0]     y_arr [N_REQ];
   logic [PTR_W-1:0]     win_idx;
   logic                 done;

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign x_arr[i] = req_x[i*WIDTH +: WIDTH];
      assign y_arr[i] = req_y[i*WIDTH +: WIDTH];
   end

   function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= N_REQ) s = s - N_REQ;
      return PTR_W'(s);
   endfunction

   // Scan from the farthest offset down so the nearest set bit after ptr wins.
   always_comb begin
      win_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[rot_idx(ptr_q, k)]) win_idx = rot_idx(ptr_q, k);
      end
   end

   // Only a fresh rising edge of mul_valid counts; a level left over from the
   // previous operation is ignored.
   assign done = (state_q == S_WAIT) && mul_valid && !mul_valid_dly_q;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      opx_d   = opx_q;
      opy_d   = opy_q;
      rsp_z_d = rsp_z_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               owner_d = win_idx;
               opx_d   = x_arr[win_idx];
               opy_d   = y_arr[win_idx];
               ptr_d   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (done) begin
               rsp_z_d = mul_z;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_q == CNT_MAX) begin
               rsp_z_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= S_IDLE;
         ptr_q           <= '0;
         owner_q         <= '0;
         opx_q           <= '0;
         opy_q           <= '0;
         rsp_z_q         <= '0;
         err_q           <= 1'b0;
         cnt_q           <= '0;
         mul_valid_dly_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         ptr_q           <= ptr_d;
         owner_q         <= owner_d;
         opx_q           <= opx_d;
         opy_q           <= opy_d;
         rsp_z_q         <= rsp_z_d;
         err_q           <= err_d;
         cnt_q           <= cnt_d;
         mul_valid_dly_q <= mul_valid;
      end
   end

   always_comb begin
      gnt       = '0;
      rsp_valid = '0;
      if (state_q == S_ISSUE) gnt[owner_q]       = 1'b1;
      if (state_q == S_RESP)  rsp_valid[owner_q] = 1'b1;
   end

   assign mul_start   = (state_q == S_ISSUE);
   assign timeout_err = (state_q == S_RESP) && err_q;
   assign busy        = (state_q != S_IDLE);
   assign mul_x       = opx_q;
   assign mul_y       = opy_q;
   assign rsp_z       = rsp_z_q;

endmodule

`default_nettype wire
